time_setter: RTL

TIME_SETTER -- requirements
Module: time_setter

---
 rtl/time_setter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/time_setter.sv
// Time/alarm setting controller: edits a working HH:MM copy digit by digit and
// commits it with a one-cycle load strobe, or reverts it on cancel or timeout.
module time_setter #(
    parameter int TIMEOUT_CYCLES = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_time,
    input  logic       btn_alarm,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_confirm,
    input  logic       btn_cancel,
    output logic [1:0] h1_out,
    output logic [3:0] h0_out,
    output logic [2:0] m1_out,
    output logic [3:0] m0_out,
    output logic       load_time,
    output logic       load_alarm,
    output logic       editing,
    output logic [1:0] digit_sel,
    output logic [2:0] o_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EDIT_H1 = 3'd1,
        S_EDIT_H0 = 3'd2,
        S_EDIT_M1 = 3'd3,
        S_EDIT_M0 = 3'd4
    } state_t;

    state_t     r_state, w_state_nx;
    logic [6:0] r_prev;
    logic [6:0] w_btn, w_edge;
    logic       r_target, w_target_nx;          // 0 = time, 1 = alarm
    logic [1:0] r_wh1, r_ch1, w_h1_nx;
    logic [3:0] r_wh0, r_ch0, w_h0_nx;
    logic [2:0] r_wm1, r_cm1, w_m1_nx;
    logic [3:0] r_wm0, r_cm0, w_m0_nx;
    logic       r_load_time, r_load_alarm, w_load_time_nx, w_load_alarm_nx;
    logic       w_commit;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [3:0] w_h0_max;

    // Bit order: time, alarm, next, inc, dec, confirm, cancel.
    assign w_btn    = {btn_cancel, btn_confirm, btn_dec, btn_inc, btn_next, btn_alarm, btn_time};
    assign w_edge   = w_btn & ~r_prev;
    assign w_h0_max = (r_wh1 == 2'd2) ? 4'd3 : 4'd9;

    always_comb begin
        w_state_nx      = r_state;
        w_target_nx     = r_target;
        w_h1_nx         = r_wh1;
        w_h0_nx         = r_wh0;
        w_m1_nx         = r_wm1;
        w_m0_nx         = r_wm0;
        w_load_time_nx  = 1'b0;
        w_load_alarm_nx = 1'b0;
        w_commit        = 1'b0;
        w_cnt_nx        = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (w_edge[0] || w_edge[1]) begin
                    w_state_nx  = S_EDIT_H1;
                    w_target_nx = ~w_edge[0];
                    w_h1_nx     = r_ch1;
                    w_h0_nx     = r_ch0;
                    w_m1_nx     = r_cm1;
                    w_m0_nx     = r_cm0;
                end
            end
            default: begin
                if (w_edge[6]) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                    w_h1_nx    = r_ch1;
                    w_h0_nx    = r_ch0;
                    w_m1_nx    = r_cm1;
                    w_m0_nx    = r_cm0;
                end else if (w_edge[5]) begin
                    w_state_nx      = S_IDLE;
                    w_cnt_nx        = '0;
                    w_commit        = 1'b1;
                    w_load_time_nx  = ~r_target;
                    w_load_alarm_nx = r_target;
                end else begin
                    if (w_edge[2]) begin
                        case (r_state)
                            S_EDIT_H1: w_state_nx = S_EDIT_H0;
                            S_EDIT_H0: w_state_nx = S_EDIT_M1;
                            S_EDIT_M1: w_state_nx = S_EDIT_M0;
                            default:   w_state_nx = S_EDIT_H1;
                        endcase
                    end else if (w_edge[3] || w_edge[4]) begin
                        // inc outranks dec when both rise together
                        case (r_state)
                            S_EDIT_H1: begin
                                if (w_edge[3]) w_h1_nx = (r_wh1 == 2'd2) ? 2'd0 : r_wh1 + 2'd1;
                                else           w_h1_nx = (r_wh1 == 2'd0) ? 2'd2 : r_wh1 - 2'd1;
                                if (w_h1_nx == 2'd2 && r_wh0 > 4'd3) w_h0_nx = 4'd3;
                            end
                            S_EDIT_H0: begin
                                if (w_edge[3]) w_h0_nx = (r_wh0 == w_h0_max) ? 4'd0 : r_wh0 + 4'd1;
                                else           w_h0_nx = (r_wh0 == 4'd0) ? w_h0_max : r_wh0 - 4'd1;
                            end
                            S_EDIT_M1: begin
                                if (w_edge[3]) w_m1_nx = (r_wm1 == 3'd5) ? 3'd0 : r_wm1 + 3'd1;
                                else           w_m1_nx = (r_wm1 == 3'd0) ? 3'd5 : r_wm1 - 3'd1;
                            end
                            default: begin
                                if (w_edge[3]) w_m0_nx = (r_wm0 == 4'd9) ? 4'd0 : r_wm0 + 4'd1;
                                else           w_m0_nx = (r_wm0 == 4'd0) ? 4'd9 : r_wm0 - 4'd1;
                            end
                        endcase
                    end
                    if (|w_edge) begin
                        w_cnt_nx = '0;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        w_state_nx = S_IDLE;
                        w_cnt_nx   = '0;
                        w_h1_nx    = r_ch1;
                        w_h0_nx    = r_ch0;
                        w_m1_nx    = r_cm1;
                        w_m0_nx    = r_cm0;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_prev       <= '0;
            r_target     <= 1'b0;
            r_wh1        <= '0;
            r_wh0        <= '0;
            r_wm1        <= '0;
            r_wm0        <= '0;
            r_ch1        <= '0;
            r_ch0        <= '0;
            r_cm1        <= '0;
            r_cm0        <= '0;
            r_load_time  <= 1'b0;
            r_load_alarm <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_prev       <= w_btn;
            r_target     <= w_target_nx;
            r_wh1        <= w_h1_nx;
            r_wh0        <= w_h0_nx;
            r_wm1        <= w_m1_nx;
            r_wm0        <= w_m0_nx;
            r_load_time  <= w_load_time_nx;
            r_load_alarm <= w_load_alarm_nx;
            r_cnt        <= w_cnt_nx;
            if (w_commit) begin
                r_ch1 <= r_wh1;
                r_ch0 <= r_wh0;
                r_cm1 <= r_wm1;
                r_cm0 <= r_wm0;
            end
        end
    end

    always_comb begin
        case (r_state)
            S_EDIT_H0: digit_sel = 2'd1;
            S_EDIT_M1: digit_sel = 2'd2;
            S_EDIT_M0: digit_sel = 2'd3;
            default:   digit_sel = 2'd0;
        endcase
    end

    assign h1_out     = r_wh1;
    assign h0_out     = r_wh0;
    assign m1_out     = r_wm1;
    assign m0_out     = r_wm0;
    assign load_time  = r_load_time;
    assign load_alarm = r_load_alarm;
    assign editing    = (r_state != S_IDLE);
    assign o_state    = r_state;

endmodule
